// File: rtl/axi_line_adapter.sv
// axi_line_adapter: turns one cache request into one AXI4 transaction,
// either a single beat or a NUM_BEATS-beat line burst. One transaction
// outstanding at a time. AXI_LINE_ADAPTER_CWF_EN selects wrapping
// critical-word-first line reads; line reads start at the line base without it.
module axi_line_adapter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_BEATS  = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_i,
  output logic                              gnt_o,
  input  logic                              burst_i,
  input  logic                              we_i,
  input  logic [ADDR_WIDTH-1:0]             addr_i,
  input  logic [DATA_WIDTH*NUM_BEATS-1:0]   wdata_i,
  input  logic [DATA_WIDTH*NUM_BEATS/8-1:0] be_i,
  input  logic [2:0]                        size_i,
  input  logic [ID_WIDTH-1:0]               id_i,
  output logic                              valid_o,
  output logic                              err_o,
  output logic [ID_WIDTH-1:0]               id_o,
  output logic [DATA_WIDTH*NUM_BEATS-1:0]   rdata_o,
  output logic                              cw_valid_o,
  output logic [DATA_WIDTH-1:0]             cw_o,
  output logic                              aw_valid_o,
  input  logic                              aw_ready_i,
  output logic [ADDR_WIDTH-1:0]             aw_addr_o,
  output logic [7:0]                        aw_len_o,
  output logic [2:0]                        aw_size_o,
  output logic [1:0]                        aw_burst_o,
  output logic [ID_WIDTH-1:0]               aw_id_o,
  output logic                              w_valid_o,
  input  logic                              w_ready_i,
  output logic [DATA_WIDTH-1:0]             w_data_o,
  output logic [DATA_WIDTH/8-1:0]           w_strb_o,
  output logic                              w_last_o,
  input  logic                              b_valid_i,
  output logic                              b_ready_o,
  input  logic [1:0]                        b_resp_i,
  input  logic [ID_WIDTH-1:0]               b_id_i,
  output logic                              ar_valid_o,
  input  logic                              ar_ready_i,
  output logic [ADDR_WIDTH-1:0]             ar_addr_o,
  output logic [7:0]                        ar_len_o,
  output logic [2:0]                        ar_size_o,
  output logic [1:0]                        ar_burst_o,
  output logic [ID_WIDTH-1:0]               ar_id_o,
  input  logic                              r_valid_i,
  output logic                              r_ready_o,
  input  logic [DATA_WIDTH-1:0]             r_data_i,
  input  logic [1:0]                        r_resp_i,
  input  logic                              r_last_i,
  input  logic [ID_WIDTH-1:0]               r_id_i
);

  localparam int unsigned LINE_W   = DATA_WIDTH * NUM_BEATS;
  localparam int unsigned BEAT_B   = DATA_WIDTH / 8;
  localparam int unsigned BEAT_LOG = $clog2(BEAT_B);
  localparam int unsigned CNT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(NUM_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_W / 8 - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ~ADDR_WIDTH'(BEAT_B - 1);

`ifdef AXI_LINE_ADAPTER_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ_AR, READ_R, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    burst;
  logic [2:0]              size;
  logic [ID_WIDTH-1:0]     id;
  logic [LINE_W-1:0]       wdata;
  logic [LINE_W/8-1:0]     be;
  logic [CNT_W-1:0]        cnt;
  logic                    aw_done;
  logic                    w_done;
  logic                    err;

  logic [CNT_W-1:0]        word_off;
  logic [CNT_W-1:0]        start;
  logic [CNT_W-1:0]        idx;
  logic [CNT_W-1:0]        w_idx;
  logic [CNT_W-1:0]        last_cnt;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    r_hs;
  logic                    unused_resp;

  // Only the error bit of B/R responses matters; EXOKAY vs OKAY is ignored.
  assign unused_resp = ^{b_resp_i[0], r_resp_i[0]};

  assign word_off = CNT_W'((addr >> BEAT_LOG) & ADDR_WIDTH'(NUM_BEATS - 1));
  assign start    = (CWF && burst) ? word_off : '0;
  assign idx      = (start + cnt) & LAST_BEAT;
  assign w_idx    = cnt & LAST_BEAT;
  assign last_cnt = burst ? LAST_BEAT : '0;

  assign aw_hs = aw_valid_o && aw_ready_i;
  assign w_hs  = w_valid_o && w_ready_i;
  assign r_hs  = r_ready_o && r_valid_i;

  assign gnt_o = req_i && (state == IDLE);

  assign aw_addr_o  = burst ? (addr & LINE_MASK) : addr;
  assign aw_len_o   = burst ? 8'(NUM_BEATS - 1) : 8'd0;
  assign aw_size_o  = burst ? 3'(BEAT_LOG) : size;
  assign aw_burst_o = 2'b01;
  assign aw_id_o    = id;

  assign w_data_o = wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_strb_o = be[w_idx*BEAT_B +: BEAT_B];
  assign w_last_o = (cnt == last_cnt);

  // WRAP needs at least two beats, so a one-beat line stays INCR.
  assign ar_addr_o  = burst ? (addr & (CWF ? BEAT_MASK : LINE_MASK)) : addr;
  assign ar_len_o   = aw_len_o;
  assign ar_size_o  = aw_size_o;
  assign ar_burst_o = (burst && CWF && (NUM_BEATS > 1)) ? 2'b10 : 2'b01;
  assign ar_id_o    = id;

  assign cw_valid_o = (state == READ_R) && r_valid_i &&
                      (burst ? (idx == word_off) : (cnt == '0));
  assign cw_o       = r_data_i;

  // Transaction FSM; handshake strobes and completion outputs are registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      aw_valid_o <= 1'b0;
      w_valid_o  <= 1'b0;
      b_ready_o  <= 1'b0;
      ar_valid_o <= 1'b0;
      r_ready_o  <= 1'b0;
      valid_o    <= 1'b0;
      err_o      <= 1'b0;
      id_o       <= '0;
      rdata_o    <= '0;
      addr       <= '0;
      burst      <= 1'b0;
      size       <= '0;
      id         <= '0;
      wdata      <= '0;
      be         <= '0;
      cnt        <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            addr    <= addr_i;
            burst   <= burst_i;
            size    <= size_i;
            id      <= id_i;
            wdata   <= wdata_i;
            be      <= be_i;
            cnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err     <= 1'b0;
            if (we_i) begin
              aw_valid_o <= 1'b1;
              w_valid_o  <= 1'b1;
              state      <= WRITE;
            end else begin
              ar_valid_o <= 1'b1;
              state      <= READ_AR;
            end
          end
        end
        WRITE: begin
          if (aw_hs) begin
            aw_valid_o <= 1'b0;
            aw_done    <= 1'b1;
          end
          if (w_hs) begin
            if (w_last_o) begin
              w_valid_o <= 1'b0;
              w_done    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          if ((aw_done || aw_hs) && (w_done || (w_hs && w_last_o))) begin
            b_ready_o <= 1'b1;
            state     <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (b_valid_i) begin
            b_ready_o <= 1'b0;
            id_o      <= b_id_i;
            err_o     <= b_resp_i[1];
            valid_o   <= 1'b1;
            state     <= DONE;
          end
        end
        READ_AR: begin
          if (ar_ready_i) begin
            ar_valid_o <= 1'b0;
            r_ready_o  <= 1'b1;
            cnt        <= '0;
            state      <= READ_R;
          end
        end
        READ_R: begin
          if (r_hs) begin
            rdata_o[idx*DATA_WIDTH +: DATA_WIDTH] <= r_data_i;
            cnt <= cnt + 1'b1;
            err <= err | r_resp_i[1];
            if (r_last_i) begin
              r_ready_o <= 1'b0;
              id_o      <= r_id_i;
              err_o     <= err | r_resp_i[1];
              valid_o   <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          valid_o <= 1'b0;
          err_o   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_line_adapter.sv
// Scoreboard bench for axi_line_adapter (default parameters). Expectations
// follow AXI_LINE_ADAPTER_CWF_EN when the bench is built with it.
module tb_axi_line_adapter;

  localparam int DW  = 64;
  localparam int NB  = 4;
  localparam int AWD = 64;
  localparam int IW  = 4;
  localparam int LW  = DW * NB;

`ifdef AXI_LINE_ADAPTER_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_i, req_i, gnt_o, burst_i, we_i;
  logic [AWD-1:0] addr_i;
  logic [LW-1:0]  wdata_i;
  logic [LW/8-1:0] be_i;
  logic [2:0]     size_i;
  logic [IW-1:0]  id_i;
  logic           valid_o, err_o;
  logic [IW-1:0]  id_o;
  logic [LW-1:0]  rdata_o;
  logic           cw_valid_o;
  logic [DW-1:0]  cw_o;
  logic           aw_valid_o, aw_ready_i;
  logic [AWD-1:0] aw_addr_o;
  logic [7:0]     aw_len_o;
  logic [2:0]     aw_size_o;
  logic [1:0]     aw_burst_o;
  logic [IW-1:0]  aw_id_o;
  logic           w_valid_o, w_ready_i, w_last_o;
  logic [DW-1:0]  w_data_o;
  logic [DW/8-1:0] w_strb_o;
  logic           b_valid_i, b_ready_o;
  logic [1:0]     b_resp_i;
  logic [IW-1:0]  b_id_i;
  logic           ar_valid_o, ar_ready_i;
  logic [AWD-1:0] ar_addr_o;
  logic [7:0]     ar_len_o;
  logic [2:0]     ar_size_o;
  logic [1:0]     ar_burst_o;
  logic [IW-1:0]  ar_id_o;
  logic           r_valid_i, r_ready_o, r_last_i;
  logic [DW-1:0]  r_data_i;
  logic [1:0]     r_resp_i;
  logic [IW-1:0]  r_id_i;

  axi_line_adapter #(
    .DATA_WIDTH(DW), .NUM_BEATS(NB), .ADDR_WIDTH(AWD), .ID_WIDTH(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .burst_i(burst_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .be_i(be_i), .size_i(size_i), .id_i(id_i),
    .valid_o(valid_o), .err_o(err_o), .id_o(id_o), .rdata_o(rdata_o),
    .cw_valid_o(cw_valid_o), .cw_o(cw_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
    .aw_id_o(aw_id_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
    .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .b_id_i(b_id_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
    .ar_id_o(ar_id_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
    .r_resp_i(r_resp_i), .r_last_i(r_last_i), .r_id_i(r_id_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AWD-1:0] addr;
    logic [7:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
    logic [IW-1:0]  id;
  } addr_t;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic            last;
  } wbeat_t;

  typedef struct packed {
    logic          err;
    logic [IW-1:0] id;
    logic [LW-1:0] rdata;
  } cpl_t;

  addr_t         aw_q[$];
  addr_t         ar_q[$];
  wbeat_t        w_q[$];
  cpl_t          cpl_q[$];
  logic [DW-1:0] cw_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fin_cyc = -10;
  int aw_cyc = 0;
  int w_last_cyc = 0;
  int gnt_cnt = 0;
  int w_hs_cnt = 0;

  logic [LW-1:0] line_model;
  addr_t         ea;
  wbeat_t        ew;
  cpl_t          ec;
  logic [DW-1:0] ecw;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %s", nm, what);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every DUT-presented event pops its queue and is compared.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (gnt_o) gnt_cnt++;
      if (b_valid_i && b_ready_o) fin_cyc = cyc;
      if (r_valid_i && r_ready_o && r_last_i) fin_cyc = cyc;
      if (aw_valid_o && aw_ready_i) begin
        aw_cyc = cyc;
        if (aw_q.size() == 0) flag("aw", "unexpected handshake, required none");
        else begin
          ea = aw_q.pop_front();
          check("aw", 256'({aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_id_o}), 256'(ea));
        end
      end
      if (w_valid_o && w_ready_i) begin
        w_hs_cnt++;
        if (w_last_o) w_last_cyc = cyc;
        if (w_q.size() == 0) flag("w", "unexpected handshake, required none");
        else begin
          ew = w_q.pop_front();
          check("w_beat", 256'({w_data_o, w_strb_o, w_last_o}), 256'(ew));
        end
      end
      if (ar_valid_o && ar_ready_i) begin
        if (ar_q.size() == 0) flag("ar", "unexpected handshake, required none");
        else begin
          ea = ar_q.pop_front();
          check("ar", 256'({ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o}), 256'(ea));
        end
      end
      if (cw_valid_o) begin
        if (cw_q.size() == 0) flag("cw", "unexpected strobe, required none");
        else begin
          ecw = cw_q.pop_front();
          check("cw_data", 256'(cw_o), 256'(ecw));
        end
      end
      if (valid_o) begin
        if (cpl_q.size() == 0) flag("cpl", "unexpected valid_o, required none");
        else begin
          ec = cpl_q.pop_front();
          check("cpl_err", 256'(err_o), 256'(ec.err));
          check("cpl_id", 256'(id_o), 256'(ec.id));
          check("cpl_rdata", rdata_o, ec.rdata);
          check("cpl_latency", 256'(cyc), 256'(fin_cyc + 1));
        end
      end
    end
  end

  task automatic do_req(input logic burst, input logic we, input logic [AWD-1:0] addr,
                        input logic [LW-1:0] wd, input logic [LW/8-1:0] be,
                        input logic [2:0] sz, input logic [IW-1:0] id, input bit hold);
    bit got = 0;
    @(posedge clk); #1;
    req_i = 1'b1; burst_i = burst; we_i = we; addr_i = addr;
    wdata_i = wd; be_i = be; size_i = sz; id_i = id;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt_o) begin got = 1; break; end
    end
    if (!got) flag("grant", "no gnt_o, required grant");
    @(posedge clk); #1;
    if (hold) begin
      we_i = 1'b0; burst_i = 1'b0; addr_i = 64'hFFFF_FFC0;
      wdata_i = '1; be_i = '0; size_i = 3'd0; id_i = 4'hF;
    end else begin
      req_i = 1'b0;
    end
  endtask

  task automatic accept_aw(input int delay);
    bit got = 0;
    repeat (delay) @(posedge clk);
    #1 aw_ready_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (aw_valid_o) begin got = 1; break; end
    end
    if (!got) flag("aw_wait", "no aw_valid_o, required handshake");
    @(posedge clk); #1 aw_ready_i = 1'b0;
  endtask

  task automatic accept_ar();
    bit got = 0;
    ar_ready_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ar_valid_o) begin got = 1; break; end
    end
    if (!got) flag("ar_wait", "no ar_valid_o, required handshake");
    @(posedge clk); #1 ar_ready_i = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] resp, input logic [IW-1:0] id);
    bit got = 0;
    b_valid_i = 1'b1; b_resp_i = resp; b_id_i = id;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_ready_o) begin got = 1; break; end
    end
    if (!got) flag("b_wait", "no b_ready_o, required handshake");
    @(posedge clk); #1 b_valid_i = 1'b0;
  endtask

  task automatic send_r(input logic [DW-1:0] d, input logic [1:0] resp,
                        input logic last, input logic [IW-1:0] id);
    bit got = 0;
    r_valid_i = 1'b1; r_data_i = d; r_resp_i = resp; r_last_i = last; r_id_i = id;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (r_ready_o) begin got = 1; break; end
    end
    if (!got) flag("r_wait", "no r_ready_o, required handshake");
    @(posedge clk); #1 r_valid_i = 1'b0; r_last_i = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid_o) begin got = 1; break; end
    end
    if (!got) flag("done_wait", "no valid_o, required completion");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int gnt0;
    int slot;
    rst_i = 1'b1; req_i = 1'b0; burst_i = 1'b0; we_i = 1'b0; addr_i = '0;
    wdata_i = '0; be_i = '0; size_i = '0; id_i = '0;
    aw_ready_i = 1'b0; w_ready_i = 1'b0; b_valid_i = 1'b0; b_resp_i = '0; b_id_i = '0;
    ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; r_resp_i = '0;
    r_last_i = 1'b0; r_id_i = '0;
    line_model = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset_strobes", 256'({aw_valid_o, w_valid_o, b_ready_o, ar_valid_o,
                                 r_ready_o, valid_o, err_o, cw_valid_o}), '0);
    check("reset_rdata", rdata_o, '0);

    // 1: single write, W completes before AW
    w_ready_i = 1'b1;
    aw_q.push_back('{64'h1008, 8'd0, 3'd3, 2'b01, 4'd2});
    w_q.push_back('{64'hDEADBEEF, 8'hFF, 1'b1});
    cpl_q.push_back('{1'b0, 4'd2, line_model});
    do_req(1'b0, 1'b1, 64'h1008, 256'hDEADBEEF, 32'h0000_00FF, 3'd3, 4'd2, 1'b0);
    accept_aw(3);
    send_b(2'b00, 4'd2);
    wait_done();
    check("t1_w_before_aw", 256'(w_last_cyc < aw_cyc), 256'(1));
    w_ready_i = 1'b0;

    // 2/3: line read at word offset 2
    if (CWF) ar_q.push_back('{64'h2010, 8'd3, 3'd3, 2'b10, 4'd3});
    else     ar_q.push_back('{64'h2000, 8'd3, 3'd3, 2'b01, 4'd3});
    cw_q.push_back(64'hA2);
    line_model = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    cpl_q.push_back('{1'b0, 4'd3, line_model});
    do_req(1'b1, 1'b0, 64'h2010, '0, '0, 3'd0, 4'd3, 1'b0);
    accept_ar();
    for (int k = 0; k < 4; k++) begin
      slot = CWF ? ((k + 2) % 4) : k;
      send_r(64'hA0 + 64'(slot), 2'b00, k == 3, 4'd3);
    end
    wait_done();

    // 4: line write, W throttled, AW after last W, inputs scrambled after grant
    aw_q.push_back('{64'h3020, 8'd3, 3'd3, 2'b01, 4'd5});
    w_q.push_back('{64'h1111_1111_1111_1111, 8'hFF, 1'b0});
    w_q.push_back('{64'h2222_2222_2222_2222, 8'h0F, 1'b0});
    w_q.push_back('{64'h3333_3333_3333_3333, 8'hF0, 1'b0});
    w_q.push_back('{64'h4444_4444_4444_4444, 8'h3C, 1'b1});
    cpl_q.push_back('{1'b0, 4'd5, line_model});
    gnt0 = gnt_cnt;
    base = w_hs_cnt;
    do_req(1'b1, 1'b1, 64'h3028,
           {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
           32'h3CF0_0FFF, 3'd0, 4'd5, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1 w_ready_i = ~w_ready_i;
      @(negedge clk); #1;
      if (w_hs_cnt == base + 4) break;
    end
    @(posedge clk); #1 w_ready_i = 1'b0; req_i = 1'b0;
    accept_aw(1);
    send_b(2'b00, 4'd5);
    wait_done();
    check("t4_w_beats", 256'(w_hs_cnt - base), 256'(4));
    check("t4_grants", 256'(gnt_cnt - gnt0), 256'(1));
    check("t4_aw_after_w", 256'(aw_cyc > w_last_cyc), 256'(1));

    // 5: line read with SLVERR on beat 1, then a clean single read
    if (CWF) ar_q.push_back('{64'h4000, 8'd3, 3'd3, 2'b10, 4'd4});
    else     ar_q.push_back('{64'h4000, 8'd3, 3'd3, 2'b01, 4'd4});
    cw_q.push_back(64'hB0);
    line_model = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
    cpl_q.push_back('{1'b1, 4'd4, line_model});
    do_req(1'b1, 1'b0, 64'h4000, '0, '0, 3'd0, 4'd4, 1'b0);
    accept_ar();
    for (int k = 0; k < 4; k++)
      send_r(64'hB0 + 64'(k), (k == 1) ? 2'b10 : 2'b00, k == 3, 4'd4);
    wait_done();

    ar_q.push_back('{64'h5008, 8'd0, 3'd2, 2'b01, 4'd7});
    cw_q.push_back(64'hC1);
    line_model = {64'hB3, 64'hB2, 64'hB1, 64'hC1};
    cpl_q.push_back('{1'b0, 4'd7, line_model});
    do_req(1'b0, 1'b0, 64'h5008, '0, '0, 3'd2, 4'd7, 1'b0);
    accept_ar();
    send_r(64'hC1, 2'b00, 1'b1, 4'd7);
    wait_done();

    // 6: reset in the middle of a line write, then an immediate grant
    w_ready_i = 1'b1;
    w_q.push_back('{64'h61, 8'hFF, 1'b0});
    w_q.push_back('{64'h62, 8'hFF, 1'b0});
    base = w_hs_cnt;
    do_req(1'b1, 1'b1, 64'h6000, {64'h64, 64'h63, 64'h62, 64'h61}, '1, 3'd0, 4'd6, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (w_hs_cnt == base + 2) break;
    end
    check("t6_w_beats", 256'(w_hs_cnt - base), 256'(2));
    @(posedge clk); #1 w_ready_i = 1'b0; rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    ar_q.push_back('{64'h7000, 8'd0, 3'd3, 2'b01, 4'd1});
    cw_q.push_back(64'hE0);
    line_model = {64'h0, 64'h0, 64'h0, 64'hE0};
    cpl_q.push_back('{1'b0, 4'd1, line_model});
    req_i = 1'b1; burst_i = 1'b0; we_i = 1'b0; addr_i = 64'h7000;
    size_i = 3'd3; id_i = 4'd1;
    @(negedge clk);
    check("t6_reset_strobes", 256'({aw_valid_o, w_valid_o, b_ready_o, ar_valid_o,
                                    r_ready_o, valid_o, err_o, cw_valid_o}), '0);
    check("t6_reset_rdata", rdata_o, '0);
    check("t6_regrant", 256'(gnt_o), 256'(1));
    @(posedge clk); #1 req_i = 1'b0;
    accept_ar();
    send_r(64'hE0, 2'b00, 1'b1, 4'd1);
    wait_done();

    repeat (5) @(posedge clk);
    check("aw_q_left", 256'(aw_q.size()), 256'(0));
    check("w_q_left", 256'(w_q.size()), 256'(0));
    check("ar_q_left", 256'(ar_q.size()), 256'(0));
    check("cw_q_left", 256'(cw_q.size()), 256'(0));
    check("cpl_q_left", 256'(cpl_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
